// File: rtl/fpu_op_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_op_sequencer
//
// Single-outstanding issue controller between the EX stage and the shared FPU
// datapath. It accepts one FP op over a valid/ready handshake and registers the
// opcode and operands onto the FPU inputs. It waits a per-class latency, then
// captures the FPU result and presents it to writeback over a second
// valid/ready handshake. A synchronous flush kills the op in flight.
//
// Parameters:
//   LAT_SGNJ   cycles an FSGNJ-class op (10001/10010/10011) occupies the FPU (1..15)
//   LAT_ARITH  cycles any other FP op (i_alu_op[4]==1) occupies the FPU (1..15)
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       EX-side issue handshake
//   i_alu_op, i_operand_a,
//   i_operand_b, i_rd       op presented by EX
//   i_flush                 synchronous kill of any in-flight op
//   o_fpu_op/o_fpu_a/o_fpu_b  registered FPU inputs (held outside accept)
//   i_fpu_result            combinational FPU result for o_fpu_*
//   o_wb_valid / i_wb_ready writeback handshake
//   o_wb_data, o_wb_rd      captured result and its destination
//   o_busy                  high while an op is executing or awaiting writeback
//
// Optional feature (macro FPU_SEQ_PERF_EN):
//   adds o_op_count[31:0], the number of completed writeback handshakes
//   (wraps; flushed ops are not counted).
// -----------------------------------------------------------------------------
module fpu_op_sequencer #(
  parameter int unsigned LAT_SGNJ  = 1,
  parameter int unsigned LAT_ARITH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_alu_op,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  input  logic [4:0]  i_rd,
  input  logic        i_flush,
  output logic [4:0]  o_fpu_op,
  output logic [31:0] o_fpu_a,
  output logic [31:0] o_fpu_b,
  input  logic [31:0] i_fpu_result,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_rd,
  output logic        o_busy
`ifdef FPU_SEQ_PERF_EN
  ,
  output logic [31:0] o_op_count
`endif
);

  // The 4-bit latency counter cannot represent anything outside 1..15.
  generate
    if (LAT_SGNJ < 1 || LAT_SGNJ > 15 || LAT_ARITH < 1 || LAT_ARITH > 15) begin : g_bad_latency
      $error("fpu_op_sequencer: LAT_SGNJ and LAT_ARITH must be in 1..15");
    end
  endgenerate

  // Counter is loaded with latency-1 so that "counter==0" marks the last
  // EXEC cycle and the result is sampled exactly LAT edges after accept.
  localparam logic [3:0] SGNJ_LOAD  = 4'(LAT_SGNJ - 1);
  localparam logic [3:0] ARITH_LOAD = 4'(LAT_ARITH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  count;
  logic [4:0]  rd_q;
  logic        is_sgnj;
  logic        accept;
  logic        exec_last;
  logic        wb_fire;

  assign is_sgnj   = (i_alu_op == 5'b10001) || (i_alu_op == 5'b10010) ||
                     (i_alu_op == 5'b10011);
  assign accept    = (state == IDLE) && i_valid && o_ready && !i_flush;
  assign exec_last = (state == EXEC) && (count == 4'd0) && !i_flush;
  assign wb_fire   = (state == DONE) && i_wb_ready && !i_flush;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output is defaulted first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    o_ready    = 1'b0;
    o_wb_valid = 1'b0;
    o_busy     = 1'b0;

    unique case (state)
      IDLE: begin
        // Non-FP opcodes are refused outright; EX must not issue them.
        o_ready = i_alu_op[4];
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        o_busy = 1'b1;
        if (exec_last) state_next = DONE;
      end
      DONE: begin
        o_busy     = 1'b1;
        o_wb_valid = 1'b1;
        if (wb_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Flush wins over accept and over the writeback handshake.
    if (i_flush) state_next = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Latency counter and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count     <= 4'd0;
      o_fpu_op  <= 5'd0;
      o_fpu_a   <= 32'd0;
      o_fpu_b   <= 32'd0;
      rd_q      <= 5'd0;
      o_wb_data <= 32'd0;
      o_wb_rd   <= 5'd0;
    end else begin
      if (i_flush)
        count <= 4'd0;
      else if (accept)
        count <= is_sgnj ? SGNJ_LOAD : ARITH_LOAD;
      else if (state == EXEC && count != 4'd0)
        count <= count - 4'd1;

      // FPU inputs only move on accept; they are deliberately not cleared
      // afterwards so the datapath sees stable operands.
      if (accept) begin
        o_fpu_op <= i_alu_op;
        o_fpu_a  <= i_operand_a;
        o_fpu_b  <= i_operand_b;
        rd_q     <= i_rd;
      end

      if (exec_last) begin
        o_wb_data <= i_fpu_result;
        o_wb_rd   <= rd_q;
      end
    end
  end

`ifdef FPU_SEQ_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     o_op_count <= 32'd0;
    else if (wb_fire) o_op_count <= o_op_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fpu_op_sequencer
//
// Directed testbench for fpu_op_sequencer (default LAT_SGNJ=1, LAT_ARITH=4).
// A small behavioural FPU model drives i_fpu_result: FSGNJ/FSGNJN/FSGNJX for
// the sign-inject opcodes, integer a+b for every other FP opcode.
// -----------------------------------------------------------------------------
module tb_fpu_op_sequencer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_alu_op;
  logic [31:0] i_operand_a;
  logic [31:0] i_operand_b;
  logic [4:0]  i_rd;
  logic        i_flush;
  logic [4:0]  o_fpu_op;
  logic [31:0] o_fpu_a;
  logic [31:0] o_fpu_b;
  logic [31:0] i_fpu_result;
  logic        o_wb_valid;
  logic        i_wb_ready;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_busy;
`ifdef FPU_SEQ_PERF_EN
  logic [31:0] o_op_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fpu_op_sequencer #(
    .LAT_SGNJ (1),
    .LAT_ARITH(4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_alu_op    (i_alu_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .i_rd        (i_rd),
    .i_flush     (i_flush),
    .o_fpu_op    (o_fpu_op),
    .o_fpu_a     (o_fpu_a),
    .o_fpu_b     (o_fpu_b),
    .i_fpu_result(i_fpu_result),
    .o_wb_valid  (o_wb_valid),
    .i_wb_ready  (i_wb_ready),
    .o_wb_data   (o_wb_data),
    .o_wb_rd     (o_wb_rd),
    .o_busy      (o_busy)
`ifdef FPU_SEQ_PERF_EN
    ,
    .o_op_count  (o_op_count)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural FPU datapath.
  always_comb begin
    i_fpu_result = o_fpu_a + o_fpu_b;
    case (o_fpu_op)
      5'b10001: i_fpu_result = {o_fpu_b[31], o_fpu_a[30:0]};
      5'b10010: i_fpu_result = {~o_fpu_b[31], o_fpu_a[30:0]};
      5'b10011: i_fpu_result = {o_fpu_a[31] ^ o_fpu_b[31], o_fpu_a[30:0]};
      default:  ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one op with i_wb_ready already high, wait (bounded) for the result,
  // check latency and data, then complete the writeback handshake.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int exp_lat);
    int n;
    i_valid     = 1'b1;
    i_alu_op    = op;
    i_operand_a = a;
    i_operand_b = b;
    i_rd        = rd;
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_wb_valid && n < 20);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, o_wb_data, exp_data);
    check({tag, "_rd"}, 32'(o_wb_rd), 32'(rd));
    tick();
    check({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_alu_op    = 5'b10001;
    i_operand_a = 32'd0;
    i_operand_b = 32'd0;
    i_rd        = 5'd0;
    i_flush     = 1'b0;
    i_wb_ready  = 1'b0;

    // ---- Reset values ------------------------------------------------------
    #2;
    check("rst_busy",    32'(o_busy),     32'd0);
    check("rst_wbvalid", 32'(o_wb_valid), 32'd0);
    check("rst_fpu_op",  32'(o_fpu_op),   32'd0);
    check("rst_fpu_a",   o_fpu_a,         32'd0);
    check("rst_fpu_b",   o_fpu_b,         32'd0);
    check("rst_wbdata",  o_wb_data,       32'd0);
    check("rst_wbrd",    32'(o_wb_rd),    32'd0);
    #10;
    i_rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(o_ready), 32'd1);

    // ---- FSGNJ issue, LAT_SGNJ=1 --------------------------------------------
    i_valid     = 1'b1;
    i_alu_op    = 5'b10001;
    i_operand_a = 32'h3F80_0000;
    i_operand_b = 32'h8000_0000;
    i_rd        = 5'd7;
    check("sgnj_ready", 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
    check("sgnj_busy",    32'(o_busy),     32'd1);
    check("sgnj_nready",  32'(o_ready),    32'd0);
    check("sgnj_wbv0",    32'(o_wb_valid), 32'd0);
    check("sgnj_fpu_op",  32'(o_fpu_op),   32'h11);
    check("sgnj_fpu_a",   o_fpu_a,         32'h3F80_0000);
    check("sgnj_fpu_b",   o_fpu_b,         32'h8000_0000);
    tick();
    check("sgnj_wbv1",  32'(o_wb_valid), 32'd1);
    check("sgnj_data",  o_wb_data,       32'hBF80_0000);
    check("sgnj_rd",    32'(o_wb_rd),    32'd7);
    i_wb_ready = 1'b1;
    tick();
    check("sgnj_done_wbv", 32'(o_wb_valid), 32'd0);
    check("sgnj_done_rdy", 32'(o_ready),    32'd1);

    // ---- Arith latency, LAT_ARITH=4, second i_valid held off -----------------
    i_valid     = 1'b1;
    i_alu_op    = 5'b10100;
    i_operand_a = 32'd5;
    i_operand_b = 32'd7;
    i_rd        = 5'd3;
    tick();
    // Keep presenting a different op while busy; it must not be taken.
    i_operand_a = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("arith_busy%0d", i), 32'(o_busy),     32'd1);
      check($sformatf("arith_wbv%0d", i),  32'(o_wb_valid), 32'd0);
      check($sformatf("arith_rdy%0d", i),  32'(o_ready),    32'd0);
      tick();
    end
    check("arith_busy4", 32'(o_busy),     32'd1);
    check("arith_wbv4",  32'(o_wb_valid), 32'd1);
    check("arith_data",  o_wb_data,       32'd12);
    check("arith_rd",    32'(o_wb_rd),    32'd3);
    check("arith_hold",  o_fpu_a,         32'd5);
    tick();
    check("arith_idle",  32'(o_busy),     32'd0);
    check("arith_rdy",   32'(o_ready),    32'd1);
    i_valid = 1'b0;

    // ---- Writeback backpressure ----------------------------------------------
    i_wb_ready  = 1'b0;
    i_valid     = 1'b1;
    i_alu_op    = 5'b10010;
    i_operand_a = 32'h4000_0000;
    i_operand_b = 32'h0000_0000;
    i_rd        = 5'd12;
    tick();
    // Offer another op throughout; DONE must not accept it.
    i_alu_op    = 5'b10001;
    i_operand_a = 32'h1234_5678;
    tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_wbv%0d", i),  32'(o_wb_valid), 32'd1);
      check($sformatf("bp_data%0d", i), o_wb_data,       32'hC000_0000);
      check($sformatf("bp_rd%0d", i),   32'(o_wb_rd),    32'd12);
      check($sformatf("bp_rdy%0d", i),  32'(o_ready),    32'd0);
      tick();
    end
    i_wb_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    check("bp_release_wbv",  32'(o_wb_valid), 32'd0);
    check("bp_release_busy", 32'(o_busy),     32'd0);
    check("bp_fpu_a_kept",   o_fpu_a,         32'h4000_0000);

    // ---- Flush in the 2nd EXEC cycle of an arith op --------------------------
    i_valid     = 1'b1;
    i_alu_op    = 5'b10100;
    i_operand_a = 32'd1;
    i_operand_b = 32'd2;
    i_rd        = 5'd4;
    tick();
    i_valid = 1'b0;
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("fl_busy",   32'(o_busy),  32'd0);
    check("fl_fpu_a",  o_fpu_a,      32'd1);
    check("fl_wbdata", o_wb_data,    32'hC000_0000);
    check("fl_wbrd",   32'(o_wb_rd), 32'd12);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fl_nowbv%0d", i), 32'(o_wb_valid), 32'd0);
      tick();
    end

    // ---- Flush with i_valid in IDLE: no accept -------------------------------
    i_valid     = 1'b1;
    i_flush     = 1'b1;
    i_alu_op    = 5'b10001;
    i_operand_a = 32'd9;
    tick();
    i_valid = 1'b0;
    i_flush = 1'b0;
    check("fli_busy",  32'(o_busy),   32'd0);
    check("fli_fpu_a", o_fpu_a,       32'd1);
    check("fli_fpuop", 32'(o_fpu_op), 32'h14);

    // ---- Flush beats writeback handshake in DONE -----------------------------
    i_valid     = 1'b1;
    i_alu_op    = 5'b10011;
    i_operand_a = 32'h8000_0001;
    i_operand_b = 32'h8000_0000;
    i_rd        = 5'd9;
    tick();
    i_valid = 1'b0;
    tick();
    check("fld_wbv",  32'(o_wb_valid), 32'd1);
    check("fld_data", o_wb_data,       32'h0000_0001);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("fld_wbv0", 32'(o_wb_valid), 32'd0);
    check("fld_busy", 32'(o_busy),     32'd0);
    check("fld_keep", o_wb_data,       32'h0000_0001);

    // ---- Async reset mid-EXEC ------------------------------------------------
    i_valid     = 1'b1;
    i_alu_op    = 5'b10100;
    i_operand_a = 32'd2;
    i_operand_b = 32'd3;
    i_rd        = 5'd5;
    tick();
    i_valid = 1'b0;
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(o_busy),     32'd0);
    check("arst_wbv",    32'(o_wb_valid), 32'd0);
    check("arst_fpu_a",  o_fpu_a,         32'd0);
    check("arst_wbdata", o_wb_data,       32'd0);
    #1;
    i_rst_n = 1'b1;
    tick();
    check("arst_ready", 32'(o_ready), 32'd1);

    // ---- Three completed ops and one flushed op ------------------------------
    run_op("op1", 5'b10100, 32'd10,         32'd20,         5'd1,  32'd30,         4);
    run_op("op2", 5'b10001, 32'h3F80_0000,  32'h0000_0000,  5'd2,  32'h3F80_0000,  1);
    i_valid     = 1'b1;
    i_alu_op    = 5'b10101;
    i_operand_a = 32'd1;
    i_operand_b = 32'd1;
    i_rd        = 5'd6;
    tick();
    i_valid = 1'b0;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("fl4_busy", 32'(o_busy), 32'd0);
    run_op("op3", 5'b11000, 32'hFFFF_FFFF,  32'd2,          5'd31, 32'd1,          4);
`ifdef FPU_SEQ_PERF_EN
    check("perf_count", o_op_count, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
Issue/sequencing controller that sits between the EX stage and the shared FPU datapath (sign-inject, add/mul and the other FP units). It accepts one FP operation at a time over a valid/ready handshake and registers the operands and opcode onto the FPU inputs. It waits a per-class latency, captures the FPU result, and presents it to writeback over a second valid/ready handshake. It is a single-outstanding sequencer that stalls the pipeline while busy and supports a synchronous flush.

Parameters:
LAT_SGNJ, 1, cycles an FSGNJ-class op (i_alu_op 10001/10010/10011) holds the FPU before its result is sampled; legal range 1..15
LAT_ARITH, 4, cycles any other FP op (i_alu_op[4]==1) holds the FPU before its result is sampled; legal range 1..15

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  EX presents an FP op
o_ready  output  1  sequencer can accept an op this cycle
i_alu_op  input  5  FP opcode, same encoding as the FPU datapath
i_operand_a  input  32  source A
i_operand_b  input  32  source B
i_rd  input  5  destination FP register
i_flush  input  1  synchronous kill of any in-flight op
o_fpu_op  output  5  registered opcode to the FPU datapath
o_fpu_a  output  32  registered operand A to the FPU
o_fpu_b  output  32  registered operand B to the FPU
i_fpu_result  input  32  FPU combinational result for o_fpu_*
o_wb_valid  output  1  result available
i_wb_ready  input  1  writeback consumes the result
o_wb_data  output  32  captured result
o_wb_rd  output  5  destination of the result
o_busy  output  1  high in EXEC or DONE

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values: state=IDLE, counter=0; o_fpu_op, o_fpu_a, o_fpu_b, o_wb_data and o_wb_rd are 0; o_wb_valid=0; o_busy=0; o_ready=1 after reset deasserts.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - o_ready=1.
  - An op is accepted on a rising edge where i_valid & o_ready & !i_flush.
  - On accept: latch i_alu_op, i_operand_a and i_operand_b into o_fpu_*; latch i_rd; load counter with the selected latency minus 1; go to EXEC.
  - Ops with i_alu_op[4]==0 are never accepted (o_ready=0 for them). The EX stage must not issue them.
- EXEC:
  - o_ready=0; o_fpu_* held stable.
  - If counter==0 on a rising edge: o_wb_data <= i_fpu_result, o_wb_rd <= latched rd, go to DONE.
  - Otherwise counter decrements.
- DONE:
  - o_wb_valid=1; o_wb_data and o_wb_rd held stable until handshake.
  - i_wb_ready on a rising edge: go to IDLE, o_wb_valid=0.
  - No new accept in DONE (no back-to-back overlap).
- Latency: accept at edge k → o_wb_valid high after edge k+LAT (LAT_SGNJ or LAT_ARITH). Minimum accept-to-accept spacing is LAT+2 edges with i_wb_ready held high.
- o_fpu_* keep their last value in IDLE and DONE; they are not cleared.
- Flush:
  - i_flush high on an edge in any state → state=IDLE, counter=0, o_wb_valid=0 next cycle. o_wb_data, o_wb_rd and o_fpu_* keep their values.
  - Flush takes priority over an accept in IDLE and over a writeback handshake in DONE; the result is dropped.
- Reset asserted mid-operation: immediate return to reset values; the in-flight op is lost.
- Counter is 4 bits; parameters outside 1..15 are illegal and the design must fail elaboration via a static check.

Optional Feature:
FPU_SEQ_PERF_EN:
- Defined: adds output o_op_count[31:0]. It resets to 0 and increments by 1 on every completed writeback handshake (DONE & i_wb_ready & !i_flush). It wraps from 0xFFFFFFFF to 0 and does not count flushed ops.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then FSGNJ issue: i_rst_n low, then high; i_valid=1, op=10001, a=0x3F800000, b=0x80000000, rd=7; FPU model returns sign-inject → o_ready=1 before accept; o_wb_valid high 1 edge after accept; o_wb_data=0xBF800000, o_wb_rd=7.
- Arith latency: op=10100 with LAT_ARITH=4, i_wb_ready=1 → o_busy for 5 cycles; o_wb_valid high exactly 4 edges after accept; second i_valid not accepted until IDLE.
- Writeback backpressure: i_wb_ready=0 for 6 cycles in DONE → o_wb_valid, o_wb_data and o_wb_rd stable; o_ready=0; completes on the first i_wb_ready=1 edge.
- Flush: i_flush pulsed in the 2nd EXEC cycle of an arith op → IDLE next edge; o_wb_valid never asserts. i_flush with i_valid in IDLE → no accept.
- Async reset mid-EXEC: drop i_rst_n between edges → o_busy=0 and o_wb_valid=0 immediately, without waiting for a clock edge.
- FPU_SEQ_PERF_EN: three completed ops plus one flushed op → o_op_count=3.
